// File: rtl/hydra_pkg.sv
// Shared egress definitions: buffer geometry, control-frame fields, FSM states.
package hydra_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 4;
    localparam int PRIO_LSB = 4;
    localparam int PRIO_W   = 3;
    localparam int LEN_LSB  = 7;
    localparam int LEN_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOP,
        ST_DATA,
        ST_EOP
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             wr_en, rd_en;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = pop_data_q;

    always_comb begin
        wr_en      = push && !full;
        rd_en      = pop && !empty;
        wr_ptr_d   = wr_en ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = rd_en ? bump(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CW'(wr_en) - CW'(rd_en);
        pop_data_d = rd_en ? mem_q[rd_ptr_q] : pop_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pop_data_q <= pop_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/egress_port.sv
// Packet egress: buffers framed words and replays whole packets
// as SOP pulse, data beats, EOP pulse once the sink is ready.
module egress_port
    import hydra_pkg::*;
#(
    parameter int DATA_W = hydra_pkg::DATA_W,
    parameter int DEPTH  = hydra_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              ready,
    output logic              rd_sop,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_eop,
    output logic [DEST_W-1:0] dest_port,
    output logic [PRIO_W-1:0] prior,
    output logic [LEN_W-1:0]  length,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = DATA_W + 1;

    logic [FW-1:0] fifo_q;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push, pop, head_last;

    state_e state_q, state_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

    logic              rd_sop_q, rd_sop_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_eop_q, rd_eop_d;
    logic              rd_last_q, rd_last_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [PRIO_W-1:0] prio_q, prio_d;
    logic [LEN_W-1:0]  len_q, len_d;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_last, in_data}),
        .pop       (pop),
        .pop_data  (fifo_q),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready  = (fifo_count < CW'(DEPTH));
    assign push      = in_vld && !fifo_full;
    assign head_last = fifo_q[FW-1];

    assign rd_sop    = rd_sop_q;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_data_q;
    assign rd_eop    = rd_eop_q;
    assign dest_port = dest_q;
    assign prior     = prio_q;
    assign length    = len_q;
    assign busy      = busy_q;

    assign pkt_cnt_d = pkt_cnt_q
                     + CW'(push && in_last)
                     - CW'(state_q == ST_EOP);

    // The FIFO read port runs one word ahead of rd_data, so popping
    // stops as soon as the stored-last word reaches the FIFO output.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        rd_sop_d  = 1'b0;
        rd_vld_d  = 1'b0;
        rd_eop_d  = 1'b0;
        rd_last_d = 1'b0;
        rd_data_d = '0;
        dest_d    = dest_q;
        prio_d    = prio_q;
        len_d     = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pkt_cnt_q != '0 && ready && !fifo_empty) begin
                    state_d  = ST_SOP;
                    rd_sop_d = 1'b1;
                    pop      = 1'b1;
                end
            end
            ST_SOP: begin
                state_d   = ST_DATA;
                rd_vld_d  = 1'b1;
                rd_data_d = fifo_q[DATA_W-1:0];
                rd_last_d = head_last;
                pop       = !head_last;
                dest_d    = fifo_q[DEST_LSB +: DEST_W];
                prio_d    = fifo_q[PRIO_LSB +: PRIO_W];
                len_d     = fifo_q[LEN_LSB +: LEN_W];
            end
            ST_DATA: begin
                if (rd_last_q) begin
                    state_d  = ST_EOP;
                    rd_eop_d = 1'b1;
                end else begin
                    rd_vld_d  = 1'b1;
                    rd_data_d = fifo_q[DATA_W-1:0];
                    rd_last_d = head_last;
                    pop       = !head_last;
                end
            end
            ST_EOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pkt_cnt_q <= '0;
            rd_sop_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_eop_q  <= 1'b0;
            rd_last_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
            dest_q    <= '0;
            prio_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
            rd_sop_q  <= rd_sop_d;
            rd_vld_q  <= rd_vld_d;
            rd_eop_q  <= rd_eop_d;
            rd_last_q <= rd_last_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            dest_q    <= dest_d;
            prio_q    <= prio_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: tb/tb_egress_port.sv
// Randomized and directed bench for egress_port against a packet-level model.
module tb_egress_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        ready = 1'b0;
    logic        rd_sop, rd_vld, rd_eop, busy;
    logic [15:0] rd_data;
    logic [3:0]  dest_port;
    logic [2:0]  prior;
    logic [8:0]  length;

    always #5 clk = ~clk;

    egress_port dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ready     (ready),
        .rd_sop    (rd_sop),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_eop    (rd_eop),
        .dest_port (dest_port),
        .prior     (prior),
        .length    (length),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit armed = 0;

    // Model: words held in the buffer, packet being sent, start cycle.
    logic [16:0] buf_q[$];
    logic [16:0] cur[$];
    int          pkts_m = 0;
    bit          act = 0;
    int          t_start = 0;
    int          n_len = 0;
    logic [15:0] fld_m = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] d,
                        input logic l, input logic r, input logic rs,
                        output bit acc);
        int off;
        bit e_sop, e_vld, e_eop, e_busy, was_act, done;
        logic [15:0] e_data;
        @(negedge clk);
        off    = act ? cyc - t_start : -1;
        e_sop  = (off == 1);
        e_vld  = (off >= 2) && (off <= n_len + 1);
        e_eop  = (off == n_len + 2);
        e_busy = (off >= 1) && (off <= n_len + 2);
        e_data = '0;
        if (e_vld) e_data = cur[off-2][15:0];
        if (off >= 2) fld_m = cur[0][15:0];
        if (armed) begin
            chk("rd_sop", 32'(rd_sop), 32'(e_sop));
            chk("rd_vld", 32'(rd_vld), 32'(e_vld));
            chk("rd_data", 32'(rd_data), 32'(e_data));
            chk("rd_eop", 32'(rd_eop), 32'(e_eop));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("in_ready", 32'(in_ready), 32'(buf_q.size() < 64));
            chk("dest_port", 32'(dest_port), 32'(fld_m[3:0]));
            chk("prior", 32'(prior), 32'(fld_m[6:4]));
            chk("length", 32'(length), 32'(fld_m[15:7]));
        end
        in_vld  = v;
        in_data = d;
        in_last = l;
        ready   = r;
        rst     = rs;
        acc = v && !rs && (buf_q.size() < 64);
        if (rs) begin
            buf_q.delete();
            cur.delete();
            pkts_m = 0;
            act = 0;
            n_len = 0;
            fld_m = '0;
        end else begin
            was_act = act;
            if (act && off == n_len + 2) begin
                act = 0;
                pkts_m--;
            end
            if (!was_act && pkts_m > 0 && r) begin
                act = 1;
                t_start = cyc;
                cur.delete();
                done = 0;
                for (int i = 0; i < buf_q.size() && !done; i++) begin
                    cur.push_back(buf_q[i]);
                    done = buf_q[i][16];
                end
                n_len = cur.size();
            end
            if (act && (cyc - t_start) < n_len) void'(buf_q.pop_front());
            if (acc) begin
                buf_q.push_back({l, d});
                if (l) pkts_m++;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic r);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, r, 1'b0, a);
    endtask

    initial begin
        bit a;
        logic [16:0] pk[$];
        int pi;
        int len;
        logic v, r;

        tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a);
        armed = 1;
        tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a);
        idle(2, 1'b1);

        // single 4-word packet with sink ready
        tick(1'b1, 16'h0A35, 1'b0, 1'b1, 1'b0, a);
        tick(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, a);
        tick(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, a);
        tick(1'b1, 16'h3333, 1'b1, 1'b1, 1'b0, a);
        idle(10, 1'b1);
        @(posedge clk); #1;
        chk("ctrl_dest", 32'(dest_port), 32'd5);
        chk("ctrl_prior", 32'(prior), 32'd3);
        chk("ctrl_length", 32'(length), 32'd20);

        // sink holds off, then releases
        tick(1'b1, 16'h0123, 1'b0, 1'b0, 1'b0, a);
        tick(1'b1, 16'h4567, 1'b1, 1'b0, 1'b0, a);
        idle(6, 1'b0);
        @(posedge clk); #1;
        chk("hold_busy", 32'(busy), 32'd0);
        idle(10, 1'b1);

        // fill all 64 entries without draining
        for (int i = 0; i < 64; i++)
            tick(1'b1, 16'(16'h0200 + i), 1'(i == 63), 1'b0, 1'b0, a);
        @(posedge clk); #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, a);
        @(posedge clk); #1;
        chk("drop_in_ready", 32'(in_ready), 32'd0);
        idle(75, 1'b1);

        // back-to-back 1-word and 2-word packets
        tick(1'b1, 16'h0101, 1'b1, 1'b0, 1'b0, a);
        tick(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0, a);
        tick(1'b1, 16'h0303, 1'b1, 1'b0, 1'b0, a);
        idle(14, 1'b1);
        @(posedge clk); #1;
        chk("b2b_busy", 32'(busy), 32'd0);

        // in_last write coincides with rd_eop
        tick(1'b1, 16'h0A0A, 1'b1, 1'b0, 1'b0, a);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, a);
        idle(2, 1'b0);
        tick(1'b1, 16'h0B0B, 1'b1, 1'b0, 1'b0, a);
        idle(10, 1'b1);

        // randomized traffic with bursts of back-pressure
        pi = 0;
        for (int c = 0; (c < 2500 || pi != 0) && c < 5000; c++) begin
            if (pk.size() == 0) begin
                len = $urandom_range(1, 8);
                for (int k = 0; k < len; k++)
                    pk.push_back({1'(k == len - 1), 16'($urandom)});
                pi = 0;
            end
            v = ($urandom_range(0, 9) < 7);
            if (((c / 400) % 2) == 1) r = ($urandom_range(0, 9) == 0);
            else r = ($urandom_range(0, 3) != 0);
            tick(v, pk[pi][15:0], pk[pi][16], r, 1'b0, a);
            if (a) begin
                pi++;
                if (pi == pk.size()) begin
                    pk.delete();
                    pi = 0;
                end
            end
        end
        idle(120, 1'b1);

        // reset while a packet is mid-transfer
        for (int i = 0; i < 5; i++)
            tick(1'b1, 16'(16'h0700 + i), 1'(i == 4), 1'b0, 1'b0, a);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, a);
        idle(3, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_vld", 32'(rd_vld), 32'd1);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, a);
        @(posedge clk); #1;
        chk("rst_vld", 32'(rd_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_data", 32'(rd_data), 32'd0);
        idle(12, 1'b1);
        tick(1'b1, 16'h0C0C, 1'b1, 1'b1, 1'b0, a);
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
